// File: rtl/tdp_ram_arbiter_if.sv
// Requester-side and RAM-side bus of the dual-port feature-map RAM arbiter.
// The slave modport is the arbiter; master is the requester/RAM environment.
interface tdp_ram_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int RAM_WIDTH  = 8,
  parameter int ADDR_WIDTH = 11
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*RAM_WIDTH-1:0]  req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ*RAM_WIDTH-1:0]  rsp_rdata;

  logic                  ram_ena;
  logic                  ram_enb;
  logic                  ram_wea;
  logic                  ram_web;
  logic [ADDR_WIDTH-1:0] ram_addra;
  logic [ADDR_WIDTH-1:0] ram_addrb;
  logic [RAM_WIDTH-1:0]  ram_dina;
  logic [RAM_WIDTH-1:0]  ram_dinb;
  logic [RAM_WIDTH-1:0]  ram_douta;
  logic [RAM_WIDTH-1:0]  ram_doutb;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_douta, ram_doutb,
    output req_ready, rsp_valid, rsp_rdata,
    output ram_ena, ram_enb, ram_wea, ram_web, ram_addra, ram_addrb, ram_dina, ram_dinb
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_douta, ram_doutb,
    input  req_ready, rsp_valid, rsp_rdata,
    input  ram_ena, ram_enb, ram_wea, ram_web, ram_addra, ram_addrb, ram_dina, ram_dinb
  );
endinterface

// File: rtl/tdp_ram_arbiter.sv
// Round-robin arbiter granting up to two requesters per cycle onto a read-first
// true-dual-port RAM, with same-address hazard blocking and read-response routing.
module tdp_ram_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int RAM_WIDTH  = 8,
  parameter int ADDR_WIDTH = 11
) (
  input logic              clka,
  input logic              rst_n,
  tdp_ram_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]             rr_ptr;
  logic [PW-1:0]             rr_next;
  logic [PW-1:0]             sel_a;
  logic [PW-1:0]             sel_b;
  logic                      found_a;
  logic                      found_b;
  logic                      hazard;
  logic                      gnt_a;
  logic                      gnt_b;
  logic [ADDR_WIDTH-1:0]     addr_a;
  logic [ADDR_WIDTH-1:0]     addr_b;
  logic [RAM_WIDTH-1:0]      wdata_a;
  logic [RAM_WIDTH-1:0]      wdata_b;
  logic                      we_a;
  logic                      we_b;
  logic [NUM_REQ-1:0]        ready;
  logic                      pend_a;
  logic                      pend_b;
  logic [PW-1:0]             own_a;
  logic [PW-1:0]             own_b;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ*RAM_WIDTH-1:0] rsp_rdata;

  // Scan from rr_ptr: first valid requester takes port A, the next takes port B.
  always_comb begin
    int idx;
    found_a = 1'b0;
    found_b = 1'b0;
    sel_a   = '0;
    sel_b   = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (bus.req_valid[PW'(idx)]) begin
        if (!found_a) begin
          found_a = 1'b1;
          sel_a   = PW'(idx);
        end else if (!found_b) begin
          found_b = 1'b1;
          sel_b   = PW'(idx);
        end
      end
    end
  end

  always_comb begin
    addr_a  = '0;
    addr_b  = '0;
    wdata_a = '0;
    wdata_b = '0;
    we_a    = 1'b0;
    we_b    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_a == PW'(i)) begin
        addr_a  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_a = bus.req_wdata[i*RAM_WIDTH +: RAM_WIDTH];
        we_a    = bus.req_we[i];
      end
      if (sel_b == PW'(i)) begin
        addr_b  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_b = bus.req_wdata[i*RAM_WIDTH +: RAM_WIDTH];
        we_b    = bus.req_we[i];
      end
    end
  end

  // A write colliding with the other port's address loses port B; reads may share.
  assign hazard = found_a && found_b && (addr_a == addr_b) && (we_a || we_b);
  assign gnt_a  = rst_n && found_a;
  assign gnt_b  = rst_n && found_b && !hazard;

  always_comb begin
    ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready[i] = (gnt_a && (sel_a == PW'(i))) || (gnt_b && (sel_b == PW'(i)));
    end
  end

  always_comb begin
    rr_next = rr_ptr;
    if (gnt_b) begin
      rr_next = PW'((int'(sel_b) + 1) % NUM_REQ);
    end else if (gnt_a) begin
      rr_next = PW'((int'(sel_a) + 1) % NUM_REQ);
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      pend_a <= 1'b0;
      pend_b <= 1'b0;
      own_a  <= '0;
      own_b  <= '0;
    end else begin
      rr_ptr <= rr_next;
      pend_a <= gnt_a && !we_a;
      pend_b <= gnt_b && !we_b;
      own_a  <= sel_a;
      own_b  <= sel_b;
    end
  end

  // RAM output registers update at the transfer edge, so douta/doutb are
  // valid for exactly the cycle in which pend_a/pend_b are set.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pend_a && (own_a == PW'(i))) begin
        rsp_valid[i]                        = 1'b1;
        rsp_rdata[i*RAM_WIDTH +: RAM_WIDTH] = bus.ram_douta;
      end
      if (pend_b && (own_b == PW'(i))) begin
        rsp_valid[i]                        = 1'b1;
        rsp_rdata[i*RAM_WIDTH +: RAM_WIDTH] = bus.ram_doutb;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.ram_ena   = gnt_a;
  assign bus.ram_enb   = gnt_b;
  assign bus.ram_wea   = gnt_a && we_a;
  assign bus.ram_web   = gnt_b && we_b;
  assign bus.ram_addra = gnt_a ? addr_a : '0;
  assign bus.ram_addrb = gnt_b ? addr_b : '0;
  assign bus.ram_dina  = gnt_a ? wdata_a : '0;
  assign bus.ram_dinb  = gnt_b ? wdata_b : '0;
endmodule

// File: tb/tb_tdp_ram_arbiter.sv
// Bench for tdp_ram_arbiter: vector table of grants, behavioural read-first RAM,
// and a response scoreboard keyed by the cycle each read result is due.
module tb_tdp_ram_arbiter;
  localparam int NR = 4;
  localparam int RW = 8;
  localparam int AW = 11;

  typedef struct {
    logic [NR-1:0]    valid;
    logic [NR-1:0]    we;
    logic [NR*AW-1:0] addr;
    logic [NR*RW-1:0] wdata;
    logic [NR-1:0]    exp_ready;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         due;
  } sb_t;

  logic clka  = 1'b0;
  logic rst_n = 1'b0;
  always #5 clka = ~clka;

  tdp_ram_arbiter_if #(.NUM_REQ(NR), .RAM_WIDTH(RW), .ADDR_WIDTH(AW)) bus ();

  tdp_ram_arbiter #(.NUM_REQ(NR), .RAM_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
    .clka  (clka),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem   [0:2047];
  logic [7:0] model [0:2047];
  bit         ram_loaded;

  function automatic logic [7:0] pat(input int a);
    return 8'(a) ^ 8'h58;
  endfunction

  // Read-first dual-port RAM, preloaded on the first reset cycle.
  always @(posedge clka) begin
    if (!rst_n && !ram_loaded) begin
      for (int i = 0; i < 2048; i++) mem[i] <= pat(i);
      ram_loaded <= 1'b1;
    end
    if (bus.ram_ena) begin
      bus.ram_douta <= mem[bus.ram_addra];
      if (bus.ram_wea) mem[bus.ram_addra] <= bus.ram_dina;
    end
    if (bus.ram_enb) begin
      bus.ram_doutb <= mem[bus.ram_addrb];
      if (bus.ram_web) mem[bus.ram_addrb] <= bus.ram_dinb;
    end
  end

  int   tests;
  int   fails;
  int   cyc;
  sb_t  sb[$];
  vec_t vecs[19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] we,
                              input int a0, input int a1, input int a2, input int a3,
                              input logic [7:0] wd, input logic [3:0] exp);
    vec_t r;
    r.valid     = v;
    r.we        = we;
    r.addr      = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    r.wdata     = {4{wd}};
    r.exp_ready = exp;
    return r;
  endfunction

  task automatic check_rsp();
    logic [NR-1:0]    m;
    logic [NR*RW-1:0] d;
    m = '0;
    d = '0;
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].due == cyc) begin
        m[sb[k].idx]           = 1'b1;
        d[sb[k].idx*RW +: RW]  = sb[k].data;
        sb.delete(k);
      end
    end
    chk("rsp_valid", bus.rsp_valid, m);
    for (int i = 0; i < NR; i++) begin
      if (m[i]) chk($sformatf("rsp_rdata[%0d]", i), bus.rsp_rdata[i*RW +: RW], d[i*RW +: RW]);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    logic [AW-1:0] a;
    @(posedge clka);
    #1;
    bus.req_valid = v.valid;
    bus.req_we    = v.we;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    @(negedge clka);
    cyc++;
    chk({name, " ready"}, bus.req_ready, v.exp_ready);
    check_rsp();
    for (int i = 0; i < NR; i++) begin
      a = v.addr[i*AW +: AW];
      if (v.valid[i] && v.exp_ready[i] && !v.we[i]) sb.push_back('{i, model[a], cyc + 1});
    end
    for (int i = 0; i < NR; i++) begin
      a = v.addr[i*AW +: AW];
      if (v.valid[i] && v.exp_ready[i] && v.we[i]) model[a] = v.wdata[i*RW +: RW];
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    for (int i = 0; i < 2048; i++) model[i] = pat(i);
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    vecs[0]  = mk(4'hF, 4'h0, 10, 20, 30, 40, 8'h00, 4'h3);
    vecs[1]  = mk(4'hF, 4'h0, 10, 20, 30, 40, 8'h00, 4'hC);
    vecs[2]  = mk(4'hF, 4'h0, 10, 20, 30, 40, 8'h00, 4'h3);
    vecs[3]  = mk(4'hF, 4'h0, 10, 20, 30, 40, 8'h00, 4'hC);
    vecs[4]  = mk(4'h3, 4'h1,  7,  7,  0,  0, 8'h5A, 4'h1);
    vecs[5]  = mk(4'h2, 4'h0,  0,  7,  0,  0, 8'h00, 4'h2);
    vecs[6]  = mk(4'hC, 4'h0,  0,  0, 100, 100, 8'h00, 4'hC);
    vecs[7]  = mk(4'h9, 4'h8, 50,  0,  0, 50, 8'h77, 4'h1);
    vecs[8]  = mk(4'h8, 4'h8,  0,  0,  0, 50, 8'h77, 4'h8);
    vecs[9]  = mk(4'h1, 4'h0, 50,  0,  0,  0, 8'h00, 4'h1);
    vecs[10] = mk(4'h6, 4'h4,  0, 60, 61,  0, 8'h99, 4'h6);
    vecs[11] = mk(4'h9, 4'h0,  5,  0,  0,  6, 8'h00, 4'h9);
    vecs[12] = mk(4'h5, 4'h0,  5,  0, 61,  0, 8'h00, 4'h5);
    vecs[13] = mk(4'hD, 4'h0,  1,  0,  2,  3, 8'h00, 4'hC);
    vecs[14] = mk(4'hD, 4'h0,  1,  0,  2,  3, 8'h00, 4'h5);
    vecs[15] = mk(4'hD, 4'h0,  1,  0,  2,  3, 8'h00, 4'h9);
    vecs[16] = mk(4'h0, 4'h0,  0,  0,  0,  0, 8'h00, 4'h0);
    vecs[17] = mk(4'h6, 4'h6,  0, 200, 200, 0, 8'h11, 4'h2);
    vecs[18] = mk(4'h4, 4'h4,  0,  0, 200,  0, 8'h11, 4'h4);

    // Reset with every requester asking: nothing may be granted or driven.
    repeat (3) @(posedge clka);
    #1;
    bus.req_valid = '1;
    bus.req_addr  = {11'd40, 11'd30, 11'd20, 11'd10};
    @(negedge clka);
    chk("rst req_ready", bus.req_ready, 0);
    chk("rst ram_ena", bus.ram_ena, 0);
    chk("rst ram_enb", bus.ram_enb, 0);
    chk("rst ram_wea", bus.ram_wea, 0);
    chk("rst ram_web", bus.ram_web, 0);
    chk("rst rsp_valid", bus.rsp_valid, 0);
    chk("rst rsp_rdata", bus.rsp_rdata, 0);
    bus.req_valid = '0;
    rst_n = 1'b1;

    for (int v = 0; v < 19; v++) begin
      apply(vecs[v], $sformatf("vec%0d", v));
      if (v == 0) begin
        chk("first addra", bus.ram_addra, 10);
        chk("first addrb", bus.ram_addrb, 20);
      end
    end

    // Single requester streaming reads: always port A, port B idle.
    for (int i = 0; i < 16; i++) begin
      apply(mk(4'h2, 4'h0, 0, i, 0, 0, 8'h00, 4'h2), $sformatf("stream%0d", i));
      chk("stream ram_ena", bus.ram_ena, 1);
      chk("stream ram_enb", bus.ram_enb, 0);
      chk("stream addra", bus.ram_addra, i);
      chk("stream addrb", bus.ram_addrb, 0);
    end

    // Reset pulsed between a read transfer and its response.
    apply(mk(4'h1, 4'h0, 300, 0, 0, 0, 8'h00, 4'h1), "pre_rst");
    @(posedge clka);
    #1;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    #2;
    rst_n = 1'b1;
    @(negedge clka);
    cyc++;
    chk("rst_mid rsp_valid", bus.rsp_valid, 0);
    sb.delete();
    apply(mk(4'h9, 4'h0, 400, 0, 0, 500, 8'h00, 4'h9), "post_rst");
    chk("post_rst addra", bus.ram_addra, 400);
    chk("post_rst addrb", bus.ram_addrb, 500);
    apply(mk(4'h0, 4'h0, 0, 0, 0, 0, 8'h00, 4'h0), "drain0");
    apply(mk(4'h0, 4'h0, 0, 0, 0, 0, 8'h00, 4'h0), "drain1");
    chk("scoreboard empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
